// File: rtl/mem_access_unit.sv
// RV32I MEM-stage data-memory access unit.
// Issues one valid/ack transaction per load/store, formats load data for MEM/WB,
// and stalls the upstream pipeline while the access is outstanding.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] readdata_out,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic        bus_error_out
);

  // Counter only has to reach TIMEOUT_CYCLES-1 before the abort fires.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               req_q;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [3:0]         wstrb_q;
  logic [31:0]        wdata_q;
  logic [2:0]         f3_q;
  logic [1:0]         off_q;
  logic [31:0]        rdata_q;
  logic               berr_q;

  logic               acc_c;
  logic               mis_c;
  logic               timeout_c;
  logic [1:0]         off_c;
  logic [3:0]         wstrb_d;
  logic [31:0]        wdata_d;
  logic [7:0]         byte_c;
  logic [15:0]        half_c;
  logic [31:0]        rdata_d;

  // Request decode: alignment/legality check, store strobes and lane-replicated data.
  always_comb begin
    acc_c   = memread_in | memwrite_in;
    off_c   = addr_in[1:0];
    mis_c   = 1'b1;
    wstrb_d = 4'b0000;
    wdata_d = 32'h0;
    case (funct3_in)
      3'b000:  mis_c = 1'b0;
      3'b001:  mis_c = off_c[0];
      3'b010:  mis_c = (off_c != 2'b00);
      3'b100:  mis_c = memwrite_in;
      3'b101:  mis_c = memwrite_in | off_c[0];
      default: mis_c = 1'b1;
    endcase
    if (memwrite_in) begin
      case (funct3_in[1:0])
        2'b00: begin
          wstrb_d = 4'b0001 << off_c;
          wdata_d = {4{wdata_in[7:0]}};
        end
        2'b01: begin
          wstrb_d = 4'b0011 << off_c;
          wdata_d = {2{wdata_in[15:0]}};
        end
        default: begin
          wstrb_d = 4'b1111;
          wdata_d = wdata_in;
        end
      endcase
    end
  end

  // Load formatting from the registered size/offset of the outstanding access.
  always_comb begin
    case (off_q)
      2'd0:    byte_c = mem_rdata[7:0];
      2'd1:    byte_c = mem_rdata[15:8];
      2'd2:    byte_c = mem_rdata[23:16];
      default: byte_c = mem_rdata[31:24];
    endcase
    half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  rdata_d = {{24{byte_c[7]}}, byte_c};
      3'b100:  rdata_d = {24'h0, byte_c};
      3'b001:  rdata_d = {{16{half_c[15]}}, half_c};
      3'b101:  rdata_d = {16'h0, half_c};
      default: rdata_d = mem_rdata;
    endcase
  end

  // Abort once TIMEOUT_CYCLES consecutive BUSY cycles pass without an ack; 0 disables it.
  always_comb begin
    timeout_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  // Stall and misalignment react in the IDLE cycle itself, so they are combinational.
  always_comb begin
    stall_out      = 1'b0;
    misaligned_out = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          stall_out      = acc_c & ~mis_c;
          misaligned_out = acc_c & mis_c;
        end
        ST_BUSY: stall_out = 1'b1;
        default: stall_out = 1'b0;
      endcase
    end
  end

  // Access FSM with registered bus-side outputs and load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wstrb_q <= 4'b0000;
      wdata_q <= 32'h0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      rdata_q <= 32'h0;
      berr_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc_c) begin
            if (mis_c) begin
              rdata_q <= 32'h0;
            end else begin
              req_q   <= 1'b1;
              we_q    <= memwrite_in;
              addr_q  <= {addr_in[31:2], 2'b00};
              wstrb_q <= wstrb_d;
              wdata_q <= wdata_d;
              f3_q    <= funct3_in;
              off_q   <= off_c;
              cnt_q   <= '0;
              state_q <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            req_q   <= 1'b0;
            if (!we_q) begin
              rdata_q <= rdata_d;
            end
            state_q <= ST_DONE;
          end else if (timeout_c) begin
            req_q   <= 1'b0;
            rdata_q <= 32'h0;
            berr_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          berr_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wstrb     = wstrb_q;
  assign mem_wdata     = wdata_q;
  assign readdata_out  = rdata_q;
  assign bus_error_out = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single accesses plus
// hand-written timeout, ignored-ack and reset-in-BUSY sequences.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        memread_in;
  logic        memwrite_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] readdata_out;
  logic        stall_out;
  logic        misaligned_out;
  logic        bus_error_out;

  int n_cmp;
  int n_mis;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .memread_in    (memread_in),
    .memwrite_in   (memwrite_in),
    .funct3_in     (funct3_in),
    .addr_in       (addr_in),
    .wdata_in      (wdata_in),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wstrb     (mem_wstrb),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .readdata_out  (readdata_out),
    .stall_out     (stall_out),
    .misaligned_out(misaligned_out),
    .bus_error_out (bus_error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wait_n;
    logic        exp_mis;
    logic [3:0]  exp_strb;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_rdout;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered just after a negedge with the DUT idle; leaves it idle after a negedge.
  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    memread_in  = v.rd;
    memwrite_in = v.wr;
    funct3_in   = v.f3;
    addr_in     = v.addr;
    wdata_in    = v.wdata;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;
    #1;
    check({tag, "_mis_idle"}, 32'(misaligned_out), 32'(v.exp_mis));
    check({tag, "_stall_idle"}, 32'(stall_out), 32'(!v.exp_mis));
    if (v.exp_mis) begin
      cycle();
      check({tag, "_req_mis"}, 32'(mem_req), 32'd0);
      check({tag, "_rdout_mis"}, readdata_out, v.exp_rdout);
      memread_in  = 1'b0;
      memwrite_in = 1'b0;
    end else begin
      cycle();
      for (int i = 0; i <= v.wait_n; i++) begin
        check({tag, "_req_busy"}, 32'(mem_req), 32'd1);
        check({tag, "_stall_busy"}, 32'(stall_out), 32'd1);
        check({tag, "_we"}, 32'(mem_we), 32'(v.wr));
        check({tag, "_maddr"}, mem_addr, v.exp_maddr);
        check({tag, "_wstrb"}, 32'(mem_wstrb), 32'(v.exp_strb));
        if (v.wr) check({tag, "_mwdata"}, mem_wdata, v.exp_mwdata);
        if (i == v.wait_n) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
        cycle();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
      end
      check({tag, "_req_done"}, 32'(mem_req), 32'd0);
      check({tag, "_stall_done"}, 32'(stall_out), 32'd0);
      check({tag, "_berr_done"}, 32'(bus_error_out), 32'd0);
      check({tag, "_rdout"}, readdata_out, v.exp_rdout);
      memread_in  = 1'b0;
      memwrite_in = 1'b0;
      cycle();
      check({tag, "_req_idle"}, 32'(mem_req), 32'd0);
      check({tag, "_stall_idle2"}, 32'(stall_out), 32'd0);
    end
  endtask

  initial begin
    vec_t extra;
    n_cmp = 0;
    n_mis = 0;
    //           rd    wr    f3      addr          wdata         rdata     wait mis strb     maddr         mwdata        rdout
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h00000100, 32'hDEADBEEF, 32'h0,        1, 1'b0, 4'b1111, 32'h00000100, 32'hDEADBEEF, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h00000103, 32'h0, 32'h80FF1234,        0, 1'b0, 4'b0000, 32'h00000100, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h00000103, 32'h0, 32'h80FF1234,        0, 1'b0, 4'b0000, 32'h00000100, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h00000102, 32'h0, 32'h80FF1234,        1, 1'b0, 4'b0000, 32'h00000100, 32'h0,        32'hFFFF80FF};
    vecs[4]  = '{1'b0, 1'b1, 3'b001, 32'h00000102, 32'h0000ABCD, 32'h0,        0, 1'b0, 4'b1100, 32'h00000100, 32'hABCDABCD, 32'hFFFF80FF};
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h00000102, 32'h0, 32'h0,               0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h00000000};
    vecs[6]  = '{1'b1, 1'b0, 3'b010, 32'h00000204, 32'h0, 32'h12345678,        2, 1'b0, 4'b0000, 32'h00000204, 32'h0,        32'h12345678};
    vecs[7]  = '{1'b1, 1'b0, 3'b101, 32'h00000100, 32'h0, 32'h1234F00D,        0, 1'b0, 4'b0000, 32'h00000100, 32'h0,        32'h0000F00D};
    vecs[8]  = '{1'b0, 1'b1, 3'b000, 32'h00000101, 32'h000000A5, 32'h0,        0, 1'b0, 4'b0010, 32'h00000100, 32'hA5A5A5A5, 32'h0000F00D};
    vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h00000000, 32'h0, 32'h0,               0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h00000000};
    vecs[10] = '{1'b0, 1'b1, 3'b100, 32'h00000000, 32'h000000FF, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h00000000};
    vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h00000101, 32'h0, 32'h00007F00,        0, 1'b0, 4'b0000, 32'h00000100, 32'h0,        32'h0000007F};
    vecs[12] = '{1'b0, 1'b1, 3'b001, 32'h00000101, 32'h00001234, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        32'h00000000};
    vecs[13] = '{1'b1, 1'b1, 3'b010, 32'h00000008, 32'h11223344, 32'h0,        0, 1'b0, 4'b1111, 32'h00000008, 32'h11223344, 32'h00000000};

    reset       = 1'b1;
    memread_in  = 1'b0;
    memwrite_in = 1'b0;
    funct3_in   = 3'b000;
    addr_in     = 32'h0;
    wdata_in    = 32'h0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Reset state
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_stall", 32'(stall_out), 32'd0);
    check("rst_mis", 32'(misaligned_out), 32'd0);
    check("rst_berr", 32'(bus_error_out), 32'd0);
    check("rst_rdout", readdata_out, 32'd0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Preload a nonzero result so the timeout clear is observable
    extra = '{1'b1, 1'b0, 3'b010, 32'h00000040, 32'h0, 32'h55AA55AA, 0, 1'b0, 4'b0000, 32'h00000040, 32'h0, 32'h55AA55AA};
    run_vec(extra, 100);

    // Timeout: no ack for 4 BUSY cycles
    memread_in = 1'b1;
    funct3_in  = 3'b010;
    addr_in    = 32'h00000010;
    cycle();
    for (int i = 0; i < 4; i++) begin
      check("to_req_busy", 32'(mem_req), 32'd1);
      check("to_stall_busy", 32'(stall_out), 32'd1);
      check("to_berr_busy", 32'(bus_error_out), 32'd0);
      cycle();
    end
    check("to_req_done", 32'(mem_req), 32'd0);
    check("to_berr_done", 32'(bus_error_out), 32'd1);
    check("to_rdout_done", readdata_out, 32'd0);
    check("to_stall_done", 32'(stall_out), 32'd0);
    memread_in = 1'b0;
    cycle();
    check("to_berr_idle", 32'(bus_error_out), 32'd0);
    check("to_req_idle", 32'(mem_req), 32'd0);

    // Ack while idle is ignored
    mem_ack   = 1'b1;
    mem_rdata = 32'hBADBAD00;
    cycle();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    check("ign_req", 32'(mem_req), 32'd0);
    check("ign_rdout", readdata_out, 32'd0);

    // Preload again, then reset while BUSY
    extra = '{1'b1, 1'b0, 3'b010, 32'h00000044, 32'h0, 32'h0BADF00D, 0, 1'b0, 4'b0000, 32'h00000044, 32'h0, 32'h0BADF00D};
    run_vec(extra, 101);
    memread_in = 1'b1;
    funct3_in  = 3'b010;
    addr_in    = 32'h00000020;
    cycle();
    check("rb_req_busy", 32'(mem_req), 32'd1);
    reset      = 1'b1;
    memread_in = 1'b0;
    cycle();
    check("rb_req", 32'(mem_req), 32'd0);
    check("rb_stall", 32'(stall_out), 32'd0);
    check("rb_rdout", readdata_out, 32'd0);
    reset = 1'b0;
    cycle();
    extra = '{1'b1, 1'b0, 3'b010, 32'h00000024, 32'h0, 32'hCAFEF00D, 1, 1'b0, 4'b0000, 32'h00000024, 32'h0, 32'hCAFEF00D};
    run_vec(extra, 102);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
